fu_wb_arbiter: RTL and testbench
================================

# fu_wb_arbiter

Parametrised writeback arbiter that collects results from NR_FU independently-timed functional units and drives NR_WB_PORTS scoreboard write ports. It sits between the execute-stage units and the scoreboard. It replaces the fixed-priority, unbuffered single-port result mux with per-unit buffering, round-robin fairness, backpressure toward each unit, and flush.

## Interface
Parameters:
- NR_FU, 4, number of producing functional units (≥2)
- NR_WB_PORTS, 2, number of scoreboard write ports (1..NR_FU)
- DEPTH, 2, entries per per-unit buffer (≥1)
- DATA_W, 64, result width

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all buffered results
- fu_valid_i  in  [NR_FU]  unit i presents a result
- fu_ready_o  out  [NR_FU]  unit i's buffer can accept
- fu_result_i  in  [NR_FU][DATA_W]  result data
- fu_trans_id_i  in  [NR_FU][TRANS_ID_BITS]  scoreboard entry ID
- fu_exception_i  in  [NR_FU] exception_t  exception carried with result
- wb_valid_o  out  [NR_WB_PORTS]  port k carries a result
- wb_ready_i  in  [NR_WB_PORTS]  scoreboard accepts on port k
- wb_result_o  out  [NR_WB_PORTS][DATA_W]  result
- wb_trans_id_o  out  [NR_WB_PORTS][TRANS_ID_BITS]  entry ID
- wb_exception_o  out  [NR_WB_PORTS] exception_t  exception
- busy_o  out  1  any buffer non-empty

## Operation
- Each unit i owns one FIFO of DEPTH entries holding {result, trans_id, exception}.
- Push on fu_valid_i[i] & fu_ready_o[i]. fu_ready_o[i] = !full[i] & !rst_i. It does not look ahead to a same-cycle pop, which keeps the path from wb_ready_i to fu_ready_o combinationally cut.
- Grant order: scan FIFO heads starting at rr_q and increasing modulo NR_FU. The k-th non-empty head found drives port k. Ports beyond the number of non-empty heads show wb_valid_o=0.
- Pop FIFO i when its assigned port has wb_valid_o & wb_ready_i. An unaccepted port holds the same head next cycle; the grant is re-evaluated but the content is stable as long as rr_q is unchanged.
- rr_q update: if at least one pop occurs, rr_q <= (index of the last popped unit in scan order + 1) mod NR_FU. Otherwise rr_q holds.
- Ordering: results from one unit leave in arrival order. There is no ordering between units.
- Silencing: wb_result_o, wb_trans_id_o and wb_exception_o are '0 whenever the matching wb_valid_o=0.
- Flush: while flush_i=1, all wb_valid_o=0 and no pops occur. At the clock edge, every FIFO empties and rr_q <= 0. A push in the flush cycle is accepted by the handshake but dropped.
- Reset: all FIFOs empty, rr_q=0. While rst_i=1: wb_valid_o=0, all data outputs 0, fu_ready_o=0, busy_o=0.
- Elaboration assertions: NR_WB_PORTS ≤ NR_FU, DEPTH ≥ 1.

## Timing
- Latency: a result pushed in cycle t is visible on a port no earlier than cycle t+1. There is no combinational bypass.
- Throughput per unit: 1/cycle for DEPTH≥2 when the port always accepts. 1 per 2 cycles for DEPTH=1.
- Full FIFO with a same-cycle pop: ready stays low that cycle and rises the next cycle.
- Full FIFO with flush: ready rises in the cycle after the flush.
- Outputs are combinational from registered state (FIFO heads, rr_q) plus wb_ready_i, but only within the grant-to-pop path. wb_valid_o and data do not depend on wb_ready_i.
- Pointer arithmetic: DEPTH not a power of two requires explicit wrap at DEPTH-1. Count width is clog2(DEPTH+1).

## Structure
- ariane_pkg additions:
  - wb_entry_t: packed struct {result[63:0], trans_id[TRANS_ID_BITS-1:0], exception_t ex}
  - NR_WB_PORTS default constant
- Reused from ariane_pkg: exception_t and TRANS_ID_BITS.
- Sub-module wb_buffer: single-clock FIFO of wb_entry_t, parameter DEPTH, outputs full/empty/head, synchronous flush. Instantiated NR_FU times in a generate loop.
- Top level: a round-robin multi-grant scan, the rr_q register, and the output silencing.

## Test plan
- Reset: hold rst_i 3 cycles with fu_valid_i=4'b1111 → fu_ready_o=0, wb_valid_o=0, busy_o=0. After release, fu_ready_o=4'b1111 next cycle.
- Round-robin, NR_WB_PORTS=1: push unit0 (id 1) and unit2 (id 3) in cycle 0; wb_ready_i=1.
  - Cycle 1: port0 = id 1 (rr_q=0); rr_q→1.
  - Cycle 2: port0 = id 3; rr_q→3.
- Dual port: all 4 units push ids 0..3 in cycle 0 →
  - Cycle 1: port0=id0, port1=id1; rr_q→2.
  - Cycle 2: port0=id2, port1=id3.
- Backpressure, DEPTH=2: unit1 pushes each cycle, wb_ready_i=0 → fu_ready_o[1] falls after 2 pushes. Raising wb_ready_i drains ids in push order, and ready rises one cycle after the first pop.
- Flush: 3 entries buffered plus a push in the flush cycle → wb_valid_o=0 during flush. Next cycle: busy_o=0, rr_q=0, nothing from the flush-cycle push ever appears.
- Exception passthrough: unit3 pushes exception_t {valid=1, cause=5, tval=0x80} → emitted unchanged with matching trans_id. Its wb_result_o equals the pushed value.

Source files
------------

// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: exception payload, buffered writeback entry.
package fu_wb_arbiter_pkg;

    localparam int unsigned XLEN            = 64;
    localparam int unsigned TRANS_ID_BITS   = 3;
    localparam int unsigned DEF_NR_WB_PORTS = 2;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        exception_t               ex;
    } wb_entry_t;

endpackage

// File: rtl/fu_wb_arbiter_wb_buffer.sv
// wb_buffer: per-unit FIFO of writeback entries with synchronous flush.
// Ports: clk_i, rst_i (sync, active-high), flush_i, push_i/entry_i (write side),
//        pop_i/head_o (read side), full_o, empty_o.
module fu_wb_arbiter_wb_buffer
    import fu_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      flush_i,
    input  logic      push_i,
    input  wb_entry_t entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer/count next state; flush wins over any same-cycle push or pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; empty entries are never presented.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !rst_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: buffers results from NR_FU units and grants up to
// NR_WB_PORTS non-empty heads per cycle in round-robin order.
// Ports: clk_i, rst_i (sync, active-high), flush_i; per-unit fu_valid_i/fu_ready_o
//        with fu_result_i/fu_trans_id_i/fu_exception_i; per-port wb_valid_o/wb_ready_i
//        with wb_result_o/wb_trans_id_o/wb_exception_o; busy_o (any buffer non-empty).
module fu_wb_arbiter
    import fu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NR_FU       = 4,
    parameter int unsigned NR_WB_PORTS = DEF_NR_WB_PORTS,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned DATA_W      = 64
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      flush_i,
    input  logic       [NR_FU-1:0]                    fu_valid_i,
    output logic       [NR_FU-1:0]                    fu_ready_o,
    input  logic       [NR_FU-1:0][DATA_W-1:0]        fu_result_i,
    input  logic       [NR_FU-1:0][TRANS_ID_BITS-1:0] fu_trans_id_i,
    input  exception_t [NR_FU-1:0]                    fu_exception_i,
    output logic       [NR_WB_PORTS-1:0]              wb_valid_o,
    input  logic       [NR_WB_PORTS-1:0]              wb_ready_i,
    output logic       [NR_WB_PORTS-1:0][DATA_W-1:0]  wb_result_o,
    output logic       [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o,
    output exception_t [NR_WB_PORTS-1:0]              wb_exception_o,
    output logic                                      busy_o
);

    localparam int unsigned IDX_W  = $clog2(NR_FU);
    localparam int unsigned PORT_W = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

    if (NR_FU < 2 || NR_WB_PORTS < 1 || NR_WB_PORTS > NR_FU || DEPTH < 1 || DATA_W > 64)
    begin : g_bad_cfg
        $error("fu_wb_arbiter: invalid parameter combination");
    end

    wb_entry_t                             fu_entry [NR_FU];
    wb_entry_t                             head     [NR_FU];
    logic      [NR_FU-1:0]                 full, empty, push, pop;
    logic      [IDX_W-1:0]                 rr_q, rr_d;
    logic      [NR_WB_PORTS-1:0]           grant_vld;
    logic      [NR_WB_PORTS-1:0][IDX_W-1:0] grant_src;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NR_FU - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    // Ready ignores same-cycle pops so wb_ready_i never reaches fu_ready_o.
    assign fu_ready_o = ~full & {NR_FU{~rst_i}};
    assign push       = fu_valid_i & fu_ready_o;
    assign busy_o     = ~rst_i & ~(&empty);

    for (genvar gi = 0; gi < NR_FU; gi++) begin : g_buf
        assign fu_entry[gi].result   = 64'(fu_result_i[gi]);
        assign fu_entry[gi].trans_id = fu_trans_id_i[gi];
        assign fu_entry[gi].ex       = fu_exception_i[gi];

        fu_wb_arbiter_wb_buffer #(
            .DEPTH (DEPTH)
        ) i_wb_buffer (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .push_i  (push[gi]),
            .entry_i (fu_entry[gi]),
            .pop_i   (pop[gi]),
            .head_o  (head[gi]),
            .full_o  (full[gi]),
            .empty_o (empty[gi])
        );
    end

    // Multi-grant scan from rr_q: the n-th non-empty head found drives port n.
    always_comb begin
        int unsigned      n;
        logic [IDX_W-1:0] idx;
        grant_vld = '0;
        grant_src = '0;
        n         = 0;
        idx       = rr_q;
        for (int j = 0; j < int'(NR_FU); j++) begin
            if (!empty[idx] && n < NR_WB_PORTS) begin
                grant_vld[PORT_W'(n)] = 1'b1;
                grant_src[PORT_W'(n)] = idx;
                n = n + 1;
            end
            idx = idx_inc(idx);
        end
        if (flush_i || rst_i) grant_vld = '0;
    end

    // Ports are in scan order, so the highest accepting port is the last pop.
    always_comb begin
        pop  = '0;
        rr_d = rr_q;
        for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
            if (grant_vld[k] && wb_ready_i[k]) begin
                pop[grant_src[k]] = 1'b1;
                rr_d              = idx_inc(grant_src[k]);
            end
        end
        if (flush_i) rr_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rr_q <= '0;
        else       rr_q <= rr_d;
    end

    // Data outputs are silenced on idle ports.
    always_comb begin
        wb_valid_o     = grant_vld;
        wb_result_o    = '0;
        wb_trans_id_o  = '0;
        wb_exception_o = '0;
        for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
            if (grant_vld[k]) begin
                wb_result_o[k]    = DATA_W'(head[grant_src[k]].result);
                wb_trans_id_o[k]  = head[grant_src[k]].trans_id;
                wb_exception_o[k] = head[grant_src[k]].ex;
            end
        end
    end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Randomized + directed bench for fu_wb_arbiter against a queue-based reference model.
module tb_fu_wb_arbiter;
    import fu_wb_arbiter_pkg::*;

    localparam int NFU = 4;
    localparam int NP  = 2;
    localparam int DEP = 2;

    logic                    clk = 1'b0;
    logic                    rst_i, flush_i;
    logic [NFU-1:0]          fu_valid_i, fu_ready_o;
    logic [NFU-1:0][63:0]    fu_result_i;
    logic [NFU-1:0][TRANS_ID_BITS-1:0] fu_trans_id_i;
    exception_t [NFU-1:0]    fu_exception_i;
    logic [NP-1:0]           wb_valid_o, wb_ready_i;
    logic [NP-1:0][63:0]     wb_result_o;
    logic [NP-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o;
    exception_t [NP-1:0]     wb_exception_o;
    logic                    busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    wb_entry_t q [NFU][$];
    int        rr = 0;

    always #5 clk = ~clk;

    fu_wb_arbiter #(
        .NR_FU       (NFU),
        .NR_WB_PORTS (NP),
        .DEPTH       (DEP),
        .DATA_W      (64)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .fu_valid_i     (fu_valid_i),
        .fu_ready_o     (fu_ready_o),
        .fu_result_i    (fu_result_i),
        .fu_trans_id_i  (fu_trans_id_i),
        .fu_exception_i (fu_exception_i),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_result_o    (wb_result_o),
        .wb_trans_id_o  (wb_trans_id_o),
        .wb_exception_o (wb_exception_o),
        .busy_o         (busy_o)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    // Move from posedge+1 to mid-cycle where outputs are sampled.
    task automatic settle();
        #3;
    endtask

    // Compare every output with the model, then advance the model and the clock.
    task automatic tick();
        int            g_src [NP];
        logic [NP-1:0] g_vld;
        logic [NFU-1:0] rdy_e;
        int            n, u, last, total;
        bit            any;
        wb_entry_t     e, pe;

        g_vld = '0;
        n     = 0;
        total = 0;
        for (int k = 0; k < NP; k++) g_src[k] = 0;
        for (int i = 0; i < NFU; i++) total += q[i].size();
        if (!rst_i && !flush_i) begin
            for (int j = 0; j < NFU; j++) begin
                u = (rr + j) % NFU;
                if (q[u].size() > 0 && n < NP) begin
                    g_src[n] = u;
                    g_vld[n] = 1'b1;
                    n++;
                end
            end
        end
        for (int i = 0; i < NFU; i++) rdy_e[i] = !rst_i && (q[i].size() < DEP);

        chk("fu_ready", 256'(fu_ready_o), 256'(rdy_e));
        chk("busy", 256'(busy_o), 256'(!rst_i && total > 0));
        chk("wb_valid", 256'(wb_valid_o), 256'(g_vld));
        for (int k = 0; k < NP; k++) begin
            e = g_vld[k] ? q[g_src[k]][0] : '0;
            chk($sformatf("port%0d_payload", k),
                256'({wb_result_o[k], wb_trans_id_o[k], wb_exception_o[k]}), 256'(e));
        end

        if (rst_i) begin
            for (int i = 0; i < NFU; i++) q[i].delete();
            rr = 0;
        end else begin
            any  = 0;
            last = 0;
            for (int i = 0; i < NFU; i++) begin
                if (fu_valid_i[i] && rdy_e[i]) begin
                    pe.result   = fu_result_i[i];
                    pe.trans_id = fu_trans_id_i[i];
                    pe.ex       = fu_exception_i[i];
                    q[i].push_back(pe);
                end
            end
            for (int k = 0; k < NP; k++) begin
                if (g_vld[k] && wb_ready_i[k]) begin
                    void'(q[g_src[k]].pop_front());
                    last = g_src[k];
                    any  = 1;
                end
            end
            if (flush_i) begin
                for (int i = 0; i < NFU; i++) q[i].delete();
                rr = 0;
            end else if (any) begin
                rr = (last + 1) % NFU;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    function automatic exception_t rand_ex();
        exception_t x;
        x.cause = {$urandom, $urandom};
        x.tval  = {$urandom, $urandom};
        x.valid = 1'($urandom % 2);
        return x;
    endfunction

    task automatic set_unit(input int i, input int id, input logic [63:0] res, input exception_t ex);
        fu_trans_id_i[i]  = TRANS_ID_BITS'(id);
        fu_result_i[i]    = res;
        fu_exception_i[i] = ex;
    endtask

    exception_t ex_ref;

    initial begin
        rst_i      = 1'b1;
        flush_i    = 1'b0;
        fu_valid_i = '1;
        wb_ready_i = '1;
        for (int i = 0; i < NFU; i++) set_unit(i, i, {$urandom, $urandom}, '0);
        @(posedge clk);
        #1;

        // Reset holds everything quiet even with all units presenting.
        repeat (3) begin
            settle();
            chk("rst_ready", 256'(fu_ready_o), 256'(0));
            chk("rst_valid", 256'(wb_valid_o), 256'(0));
            chk("rst_busy", 256'(busy_o), 256'(0));
            tick();
        end
        rst_i      = 1'b0;
        fu_valid_i = '0;
        settle();
        chk("ready_after_rst", 256'(fu_ready_o), 256'(4'hF));
        tick();

        // Dual port: ids 0..3 pushed together leave as 0/1 then 2/3.
        for (int i = 0; i < NFU; i++) set_unit(i, i, {$urandom, $urandom}, '0);
        fu_valid_i = '1;
        cycle();
        fu_valid_i = '0;
        settle();
        chk("dual_c1_p0", 256'(wb_trans_id_o[0]), 256'(0));
        chk("dual_c1_p1", 256'(wb_trans_id_o[1]), 256'(1));
        tick();
        settle();
        chk("dual_c2_p0", 256'(wb_trans_id_o[0]), 256'(2));
        chk("dual_c2_p1", 256'(wb_trans_id_o[1]), 256'(3));
        tick();

        // Single accepting port: rr advances past the popped unit only.
        wb_ready_i = 2'b01;
        set_unit(0, 1, 64'h11, '0);
        set_unit(2, 3, 64'h33, '0);
        fu_valid_i = 4'b0101;
        cycle();
        fu_valid_i = '0;
        settle();
        chk("rr_c1_p0", 256'(wb_trans_id_o[0]), 256'(1));
        tick();
        settle();
        chk("rr_c2_p0", 256'(wb_trans_id_o[0]), 256'(3));
        tick();
        wb_ready_i = '1;
        cycle();

        // Backpressure on unit1 with DEPTH=2.
        wb_ready_i = '0;
        fu_valid_i = 4'b0010;
        set_unit(1, 4, 64'h44, '0);
        cycle();
        set_unit(1, 5, 64'h55, '0);
        cycle();
        set_unit(1, 6, 64'h66, '0);
        settle();
        chk("bp_full_ready", 256'(fu_ready_o[1]), 256'(0));
        tick();
        wb_ready_i = '1;
        settle();
        chk("bp_pop_ready_low", 256'(fu_ready_o[1]), 256'(0));
        chk("bp_first_out", 256'(wb_trans_id_o[0]), 256'(4));
        tick();
        settle();
        chk("bp_ready_rises", 256'(fu_ready_o[1]), 256'(1));
        chk("bp_second_out", 256'(wb_trans_id_o[0]), 256'(5));
        tick();
        fu_valid_i = '0;
        repeat (3) cycle();

        // Flush with three buffered entries and a push in the flush cycle.
        wb_ready_i = '0;
        for (int i = 0; i < 3; i++) set_unit(i, i + 1, {$urandom, $urandom}, rand_ex());
        fu_valid_i = 4'b0111;
        cycle();
        flush_i    = 1'b1;
        fu_valid_i = 4'b1000;
        set_unit(3, 7, 64'h77, '0);
        settle();
        chk("flush_valid", 256'(wb_valid_o), 256'(0));
        chk("flush_push_ready", 256'(fu_ready_o[3]), 256'(1));
        tick();
        flush_i    = 1'b0;
        fu_valid_i = '0;
        wb_ready_i = '1;
        settle();
        chk("post_flush_busy", 256'(busy_o), 256'(0));
        chk("post_flush_valid", 256'(wb_valid_o), 256'(0));
        tick();

        // Exception passthrough; unit0 first proves rr restarted at 0.
        ex_ref.cause = 64'd5;
        ex_ref.tval  = 64'h80;
        ex_ref.valid = 1'b1;
        set_unit(0, 2, 64'h1234, '0);
        set_unit(3, 6, 64'hDEAD_BEEF_0BAD_F00D, ex_ref);
        fu_valid_i = 4'b1001;
        cycle();
        fu_valid_i = '0;
        settle();
        chk("exc_p0_id", 256'(wb_trans_id_o[0]), 256'(2));
        chk("exc_p1_id", 256'(wb_trans_id_o[1]), 256'(6));
        chk("exc_p1_ex", 256'(wb_exception_o[1]), 256'(ex_ref));
        chk("exc_p1_res", 256'(wb_result_o[1]), 256'(64'hDEAD_BEEF_0BAD_F00D));
        tick();

        // Randomized traffic with occasional flush and reset.
        repeat (600) begin
            for (int i = 0; i < NFU; i++) set_unit(i, int'($urandom % 8), {$urandom, $urandom}, rand_ex());
            fu_valid_i = 4'($urandom);
            wb_ready_i = 2'($urandom);
            flush_i    = ($urandom_range(0, 19) == 0);
            rst_i      = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst_i   = 1'b0;
        flush_i = 1'b0;
        fu_valid_i = '0;
        wb_ready_i = '1;
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
